// File: rtl/tcp_tx_drr_sched.sv
// Deficit-round-robin grant scheduler for the shared TCP TX path.
// One grant in flight at a time; per-region outstanding credit limit.
module tcp_tx_drr_sched #(
    parameter int N_REQ       = 4,
    parameter int LEN_BITS    = 16,
    parameter int MAX_OUTST   = 8,
    parameter int QUANTUM_RST = 4096
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [N_REQ-1:0]          s_req_valid,
    input  logic [N_REQ*LEN_BITS-1:0] s_req_len,
    output logic [N_REQ-1:0]          s_req_ready,
    output logic                      m_grant_valid,
    input  logic                      m_grant_ready,
    output logic [$clog2(N_REQ)-1:0]  m_grant_id,
    output logic [LEN_BITS-1:0]       m_grant_len,
    input  logic                      cmp_valid,
    input  logic [$clog2(N_REQ)-1:0]  cmp_id,
    input  logic                      cfg_we,
    input  logic [$clog2(N_REQ)-1:0]  cfg_id,
    input  logic [LEN_BITS-1:0]       cfg_quantum,
    output logic                      outst_err,
    output logic [N_REQ-1:0]          busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int OW  = $clog2(MAX_OUTST + 1);
    localparam int DW  = LEN_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_SERVE,
        ST_OUT
    } st_t;

    st_t                 r_state;
    logic [IDW-1:0]      r_ptr;
    logic [DW-1:0]       r_def   [N_REQ];
    logic [OW-1:0]       r_outst [N_REQ];
    logic [LEN_BITS-1:0] r_quant [N_REQ];
    logic                r_gvalid;
    logic [IDW-1:0]      r_gid;
    logic [LEN_BITS-1:0] r_glen;
    logic                r_err;

    logic [LEN_BITS-1:0] w_lens [N_REQ];
    logic [LEN_BITS-1:0] w_len_p;
    logic                w_elig;
    logic                w_fit;
    logic                w_grant;
    logic [DW:0]         w_sum;
    logic [DW-1:0]       w_sat;
    logic [IDW-1:0]      w_ptr_nx;
    logic                w_cmp_ok;
    logic                w_cfg_ok;
    logic                w_cmp_zero;
    logic                w_cmp_hit;

    // Region under the pointer: length, eligibility and deficit arithmetic
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_lens[i] = s_req_len[i*LEN_BITS +: LEN_BITS];
        end
        w_len_p  = w_lens[r_ptr];
        w_elig   = s_req_valid[r_ptr]
                 && (r_outst[r_ptr] < OW'(MAX_OUTST))
                 && (r_quant[r_ptr] != '0);
        w_fit    = r_def[r_ptr] >= {1'b0, w_len_p};
        w_grant  = (r_state == ST_SERVE) && w_elig && w_fit;
        w_sum    = {1'b0, r_def[r_ptr]} + {2'b0, r_quant[r_ptr]};
        w_sat    = w_sum[DW] ? {DW{1'b1}} : w_sum[DW-1:0];
        w_ptr_nx = (r_ptr == IDW'(N_REQ - 1)) ? '0 : r_ptr + IDW'(1);
    end

    // Completion / config index checks and underflow detection
    always_comb begin
        w_cmp_ok   = 32'(cmp_id) < N_REQ;
        w_cfg_ok   = 32'(cfg_id) < N_REQ;
        w_cmp_zero = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (cmp_id == IDW'(i)) w_cmp_zero = (r_outst[i] == '0);
        end
        w_cmp_hit  = w_grant && (r_ptr == cmp_id);
    end

    // Pop pulse to the region being granted in this SERVE cycle
    always_comb begin
        s_req_ready = '0;
        if (w_grant) s_req_ready[r_ptr] = 1'b1;
    end

    // Busy flags mirror non-zero outstanding counters
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            busy[i] = (r_outst[i] != '0);
        end
    end

    assign m_grant_valid = r_gvalid;
    assign m_grant_id    = r_gid;
    assign m_grant_len   = r_glen;
    assign outst_err     = r_err;

    // DRR state machine, credit counters and quantum registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_gvalid <= 1'b0;
            r_gid    <= '0;
            r_glen   <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                r_def[i]   <= '0;
                r_outst[i] <= '0;
                r_quant[i] <= LEN_BITS'(QUANTUM_RST);
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_elig) begin
                        r_state <= ST_ADD;
                    end else begin
                        if (!s_req_valid[r_ptr]) r_def[r_ptr] <= '0;
                        r_ptr <= w_ptr_nx;
                    end
                end
                ST_ADD: begin
                    r_def[r_ptr] <= w_sat;
                    r_state      <= ST_SERVE;
                end
                ST_SERVE: begin
                    if (w_grant) begin
                        r_gid        <= r_ptr;
                        r_glen       <= w_len_p;
                        r_def[r_ptr] <= r_def[r_ptr] - {1'b0, w_len_p};
                        r_gvalid     <= 1'b1;
                        r_state      <= ST_OUT;
                    end else begin
                        if (!s_req_valid[r_ptr]) r_def[r_ptr] <= '0;
                        r_ptr   <= w_ptr_nx;
                        r_state <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (m_grant_ready) begin
                        r_gvalid <= 1'b0;
                        r_state  <= ST_SERVE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            for (int i = 0; i < N_REQ; i++) begin
                if (w_grant && (r_ptr == IDW'(i))) begin
                    if (!(cmp_valid && w_cmp_ok && (cmp_id == IDW'(i)))) begin
                        r_outst[i] <= r_outst[i] + OW'(1);
                    end
                end else if (cmp_valid && w_cmp_ok && (cmp_id == IDW'(i))) begin
                    if (r_outst[i] != '0) r_outst[i] <= r_outst[i] - OW'(1);
                end
            end

            if (cmp_valid && (!w_cmp_ok || (w_cmp_zero && !w_cmp_hit))) begin
                r_err <= 1'b1;
            end

            if (cfg_we && w_cfg_ok) r_quant[cfg_id] <= cfg_quantum;
        end
    end

endmodule

// File: tb/tb_tcp_tx_drr_sched.sv
// Directed bench for tcp_tx_drr_sched with a grant scoreboard.
// Expected grants are queued as stimulus is applied and popped on handshake.
module tb_tcp_tx_drr_sched;

    localparam int N  = 4;
    localparam int LB = 16;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N-1:0]    s_req_valid;
    logic [N*LB-1:0] s_req_len;
    logic [N-1:0]    s_req_ready;
    logic            m_grant_valid;
    logic            m_grant_ready;
    logic [1:0]      m_grant_id;
    logic [LB-1:0]   m_grant_len;
    logic            cmp_valid;
    logic [1:0]      cmp_id;
    logic            cfg_we;
    logic [1:0]      cfg_id;
    logic [LB-1:0]   cfg_quantum;
    logic            outst_err;
    logic [N-1:0]    busy;

    tcp_tx_drr_sched #(
        .N_REQ(N), .LEN_BITS(LB), .MAX_OUTST(8), .QUANTUM_RST(4096)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req_valid(s_req_valid), .s_req_len(s_req_len),
        .s_req_ready(s_req_ready),
        .m_grant_valid(m_grant_valid), .m_grant_ready(m_grant_ready),
        .m_grant_id(m_grant_id), .m_grant_len(m_grant_len),
        .cmp_valid(cmp_valid), .cmp_id(cmp_id),
        .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_quantum(cfg_quantum),
        .outst_err(outst_err), .busy(busy)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [1:0]    id;
        logic [LB-1:0] len;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   hs     = 0;
    int   pulses = 0;
    int   gcnt[N];
    bit   auto_cmp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input int len, input int n);
        exp_t e;
        e.id  = 2'(id);
        e.len = LB'(len);
        repeat (n) sb.push_back(e);
    endtask

    task automatic set_len(input int i, input int v);
        s_req_len[i*LB +: LB] = LB'(v);
    endtask

    // One clock: observe handshake mid-cycle, return just after the edge
    task automatic tick();
        exp_t e;
        @(negedge aclk);
        if (|s_req_ready) pulses++;
        if (m_grant_valid && m_grant_ready) begin
            hs++;
            gcnt[m_grant_id]++;
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("grant_id", 64'(m_grant_id), 64'(e.id));
                chk("grant_len", 64'(m_grant_len), 64'(e.len));
            end
            if (auto_cmp) begin
                cmp_valid = 1'b1;
                cmp_id    = m_grant_id;
            end
        end
        @(posedge aclk);
        #1;
        if (auto_cmp) cmp_valid = 1'b0;
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        s_req_valid   = '0;
        m_grant_ready = 1'b0;
        cmp_valid     = 1'b0;
        cfg_we        = 1'b0;
        auto_cmp      = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        hs      = 0;
        pulses  = 0;
        sb.delete();
        foreach (gcnt[i]) gcnt[i] = 0;
    endtask

    initial begin
        aresetn       = 1'b0;
        s_req_valid   = '0;
        s_req_len     = '0;
        m_grant_ready = 1'b0;
        cmp_valid     = 1'b0;
        cmp_id        = '0;
        cfg_we        = 1'b0;
        cfg_id        = '0;
        cfg_quantum   = '0;
        foreach (gcnt[i]) gcnt[i] = 0;

        // Reset values
        do_reset();
        chk("rst_ready", 64'(s_req_ready), 64'd0);
        chk("rst_gvalid", 64'(m_grant_valid), 64'd0);
        chk("rst_gid", 64'(m_grant_id), 64'd0);
        chk("rst_glen", 64'(m_grant_len), 64'd0);
        chk("rst_err", 64'(outst_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Equal quanta, four regions, bursts of four
        do_reset();
        auto_cmp = 1'b1;
        for (int i = 0; i < N; i++) set_len(i, 1024);
        s_req_valid   = '1;
        m_grant_ready = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int g = 0; g < N; g++) push(g, 1024, 4);
        for (int k = 0; k < 1000 && hs < 64; k++) tick();
        m_grant_ready = 1'b0;
        chk("t1_grants", 64'(hs), 64'd64);
        for (int i = 0; i < N; i++) chk("t1_share", 64'(gcnt[i]), 64'd16);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);

        // Weighted quanta 3000:1000
        do_reset();
        auto_cmp      = 1'b1;
        set_len(0, 1000);
        set_len(1, 1000);
        s_req_valid   = 4'b0011;
        m_grant_ready = 1'b1;
        cfg_we        = 1'b1;
        cfg_id        = 2'd0;
        cfg_quantum   = 16'd3000;
        tick();
        cfg_id        = 2'd1;
        cfg_quantum   = 16'd1000;
        tick();
        cfg_we        = 1'b0;
        for (int r = 0; r < 10; r++) begin
            push(0, 1000, 3);
            push(1, 1000, 1);
        end
        for (int k = 0; k < 1000 && hs < 40; k++) tick();
        m_grant_ready = 1'b0;
        chk("t2_r0", 64'(gcnt[0]), 64'd30);
        chk("t2_r1", 64'(gcnt[1]), 64'd10);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // Outstanding cap of 8, one completion frees one grant
        do_reset();
        set_len(2, 100);
        s_req_valid   = 4'b0100;
        m_grant_ready = 1'b1;
        push(2, 100, 9);
        repeat (60) tick();
        chk("t3_cap", 64'(hs), 64'd8);
        chk("t3_busy", 64'(busy), 64'b0100);
        pulses = 0;
        repeat (30) tick();
        chk("t3_no_ready", 64'(pulses), 64'd0);
        cmp_valid = 1'b1;
        cmp_id    = 2'd2;
        tick();
        cmp_valid = 1'b0;
        repeat (30) tick();
        chk("t3_one_more", 64'(hs), 64'd9);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // Back-pressure holds the grant stable
        do_reset();
        set_len(3, 500);
        s_req_valid   = 4'b1000;
        m_grant_ready = 1'b0;
        push(3, 500, 1);
        for (int k = 0; k < 20 && !m_grant_valid; k++) tick();
        chk("t4_valid", 64'(m_grant_valid), 64'd1);
        pulses = 0;
        repeat (10) begin
            tick();
            chk("t4_hold", 64'({m_grant_valid, m_grant_id, m_grant_len}),
                64'({1'b1, 2'd3, 16'd500}));
        end
        chk("t4_no_pulse", 64'(pulses), 64'd0);
        m_grant_ready = 1'b1;
        tick();
        m_grant_ready = 1'b0;
        chk("t4_accept", 64'(hs), 64'd1);
        chk("t4_drop", 64'(m_grant_valid), 64'd0);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Completion underflow is sticky
        do_reset();
        cmp_valid = 1'b1;
        cmp_id    = 2'd1;
        tick();
        cmp_valid = 1'b0;
        chk("t5_err", 64'(outst_err), 64'd1);
        chk("t5_busy0", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("t5_sticky", 64'(outst_err), 64'd1);

        // Same-cycle grant and completion at outst=5 nets to 5
        do_reset();
        set_len(0, 100);
        s_req_valid   = 4'b0001;
        m_grant_ready = 1'b1;
        push(0, 100, 5);
        for (int k = 0; k < 50 && hs < 5; k++) tick();
        chk("t5b_hs", 64'(hs), 64'd5);
        cmp_valid     = 1'b1;
        cmp_id        = 2'd0;
        m_grant_ready = 1'b0;
        tick();
        cmp_valid = 1'b0;
        chk("t5b_noerr", 64'(outst_err), 64'd0);
        repeat (4) begin
            cmp_valid = 1'b1;
            tick();
        end
        cmp_valid = 1'b0;
        chk("t5b_busy4", 64'(busy), 64'b0001);
        cmp_valid = 1'b1;
        tick();
        cmp_valid = 1'b0;
        chk("t5b_busy5", 64'(busy), 64'd0);
        chk("t5b_err5", 64'(outst_err), 64'd0);
        cmp_valid = 1'b1;
        tick();
        cmp_valid = 1'b0;
        chk("t5b_err6", 64'(outst_err), 64'd1);
        chk("t5b_sb_empty", 64'(sb.size()), 64'd0);

        // Reset while a grant is held in ST_OUT
        do_reset();
        set_len(0, 100);
        s_req_valid   = 4'b0001;
        m_grant_ready = 1'b1;
        cfg_we        = 1'b1;
        cfg_id        = 2'd0;
        cfg_quantum   = 16'd1000;
        push(0, 100, 2);
        tick();
        cfg_id        = 2'd1;
        cfg_quantum   = 16'd0;
        tick();
        cfg_we        = 1'b0;
        for (int k = 0; k < 50 && hs < 2; k++) tick();
        m_grant_ready = 1'b0;
        tick();
        chk("t6_pre_valid", 64'(m_grant_valid), 64'd1);
        chk("t6_pre_busy", 64'(busy), 64'b0001);
        chk("t6_pre_sb", 64'(sb.size()), 64'd0);
        aresetn     = 1'b0;
        s_req_valid = '0;
        tick();
        aresetn = 1'b1;
        chk("t6_gvalid", 64'(m_grant_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_err", 64'(outst_err), 64'd0);
        chk("t6_gid", 64'(m_grant_id), 64'd0);
        chk("t6_glen", 64'(m_grant_len), 64'd0);
        chk("t6_ready", 64'(s_req_ready), 64'd0);
        hs = 0;
        set_len(0, 2048);
        set_len(1, 4096);
        s_req_valid   = 4'b0011;
        m_grant_ready = 1'b1;
        push(0, 2048, 2);
        push(1, 4096, 1);
        for (int k = 0; k < 100 && hs < 3; k++) tick();
        m_grant_ready = 1'b0;
        chk("t6_post_hs", 64'(hs), 64'd3);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcp_tx_drr_sched.md
Name: tcp_tx_drr_sched

Overview:
- Deficit-round-robin scheduler that shares the single TCP TX session/data path between N_REQ per-region requesters.
- Sits in front of the TCP TX meta arbitration. It issues one grant (region id + payload length) at a time and enforces a per-region limit on outstanding sends.
- Credits are returned from the TCP TX status path through the completion port.
- Quanta are runtime-configurable, so bandwidth shares between vFPGA regions can be weighted.

Parameters:
N_REQ, 4, number of requesting regions (>=2)
LEN_BITS, 16, request length width in bytes
MAX_OUTST, 8, max outstanding grants per region (>=1)
QUANTUM_RST, 4096, reset value of every quantum register

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_req_valid  in  N_REQ  per-region request pending
s_req_len  in  N_REQ*LEN_BITS  per-region request length, slice i = region i
s_req_ready  out  N_REQ  one-cycle pop pulse to region i
m_grant_valid  out  1  grant available
m_grant_ready  in  1  downstream accepts grant
m_grant_id  out  clog2(N_REQ)  granted region
m_grant_len  out  LEN_BITS  granted length
cmp_valid  in  1  completion, returns one credit
cmp_id  in  clog2(N_REQ)  region of completion
cfg_we  in  1  quantum write strobe
cfg_id  in  clog2(N_REQ)  quantum write index
cfg_quantum  in  LEN_BITS  quantum value
outst_err  out  1  sticky: completion received with outstanding count 0
busy  out  N_REQ  region i has outstanding count > 0

Behaviour:
- Reset:
  - ptr=0, state=ST_IDLE.
  - All deficits 0, all outstanding counters 0, all quanta = QUANTUM_RST.
  - Outputs: s_req_ready=0, m_grant_valid=0, m_grant_id=0, m_grant_len=0, outst_err=0, busy=0.
- Widths:
  - deficit[i] is LEN_BITS+1 bits; addition saturates at all-ones.
  - outst[i] is clog2(MAX_OUTST+1) bits.
- Eligibility: elig(i) = s_req_valid[i] && outst[i]<MAX_OUTST && quantum[i]!=0.
- ST_IDLE:
  - If elig(ptr), go to ST_ADD.
  - Otherwise, clear deficit[ptr] if !s_req_valid[ptr], advance ptr (wrap N_REQ-1->0), and stay in ST_IDLE.
- ST_ADD: deficit[ptr] += quantum[ptr] (saturating); go to ST_SERVE.
- ST_SERVE:
  - If elig(ptr) && deficit[ptr] >= s_req_len[ptr]:
    - Pulse s_req_ready[ptr] for this cycle.
    - Latch m_grant_id=ptr and m_grant_len=s_req_len[ptr].
    - deficit -= len; outst[ptr]++; go to ST_OUT.
  - Otherwise:
    - If !s_req_valid[ptr], clear deficit[ptr].
    - Advance ptr and go to ST_IDLE.
- ST_OUT:
  - m_grant_valid=1 with id/len stable.
  - On m_grant_ready, go to ST_SERVE with the same ptr (same region may be served again from its remaining deficit; no new quantum is added).
- Latency: region valid at ptr in ST_IDLE (cycle 0) -> ADD (1) -> SERVE with s_req_ready pulse (2) -> m_grant_valid (3). Minimum back-to-back grants to the same region: one every 2 cycles.
- Length 0: always satisfies the deficit check; deficit unchanged.
- Completion:
  - cmp_valid decrements outst[cmp_id].
  - If outst[cmp_id]==0, hold 0 and set outst_err (cleared only by reset).
  - Completion and grant on the same region in the same cycle: net unchanged.
  - cmp_id >= N_REQ: ignored, outst_err set.
- Config:
  - cfg_we writes quantum[cfg_id] at the clock edge; the new value is used from the next ST_ADD.
  - Writing 0 disables the region; its deficit is cleared when ptr next visits.
  - cfg_id >= N_REQ: ignored.
- Requester contract: s_req_len[i] is stable while s_req_valid[i]=1.
- Reset mid-operation (including in ST_OUT): all state, counters and outputs return to reset values next cycle; outstanding credits are lost by design.

Test Plan:
- Equal quanta 4096, all 4 regions requesting len 1024 continuously, m_grant_ready=1 -> grants in bursts of 4 per region in order 0,1,2,3,0..., each region gets exactly 25% of 64 grants.
- quantum[0]=3000, quantum[1]=1000, both sending len 1000, others idle -> grant ratio 3:1 over 40 grants; deficit[0] returns to 0 after each round.
- MAX_OUTST=8, region 2 only, no completions -> exactly 8 grants, then s_req_ready[2] stays 0. One cmp_valid with cmp_id=2 -> exactly 1 more grant.
- m_grant_ready held 0 for 10 cycles in ST_OUT -> m_grant_valid/id/len stable, no further s_req_ready pulses; release -> accepted next cycle.
- cmp_valid with cmp_id=1 while outst[1]=0 -> outst_err=1 and sticky; outst[1] remains 0. Simultaneous grant and completion on region 0 at outst=5 -> stays 5.
- Assert aresetn=0 for 1 cycle while in ST_OUT with outst[0]=3 -> next cycle m_grant_valid=0, busy=0, quanta=4096, and the next grant begins at region 0.
